cnt8_seq_ctrl: RTL and testbench

Sequencing controller for the team's 8-bit up counter datapath. It turns the free-running counter into a programmable interval timer, with these controls:
- configuration handshake for the limit and the mode;
- start, stop and pause control;
- count-enable gating;
- terminal-count tick generation, in one-shot or periodic mode.

It sits between software/control logic and the counter core, and is the only agent that drives the counter's clear and enable.

---
 rtl/cnt8_pkg.sv | 15 +
 rtl/cnt8_core.sv | 41 ++++
 rtl/cnt8_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_cnt8_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnt8_pkg.sv
// cnt8 shared definitions: controller state encoding
// and counter width constants.
package cnt8_pkg;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cnt8_core.sv
// cnt8 counter core: clear, enable, wrap-or-hold at limit.
// Limit match is exposed so the controller can time its tick.
module cnt8_core
  import cnt8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             hold_at_limit_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] value_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] value_q, value_d;

  assign value_o    = value_q;
  assign at_limit_o = (value_q == limit_i);

  // next value: clear wins, then wrap/hold at limit, else increment
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (en_i) begin
      if (at_limit_o) begin
        value_d = hold_at_limit_i ? value_q : '0;
      end else begin
        value_d = value_q + 8'd1;
      end
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

endmodule

// File: rtl/cnt8_seq_ctrl.sv
// cnt8 sequencing controller: config handshake, start/stop/pause,
// one-shot/periodic tick. Macro CNT8_TICK_COUNT_EN adds tick_cnt.
module cnt8_seq_ctrl
  import cnt8_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEFAULT_LIMIT    = 8'hFF,
  parameter logic             DEFAULT_PERIODIC = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             ss,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] tick_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic cfg_acc;
  logic start_go;
  logic core_clr;
  logic core_en;
  logic at_limit;

  assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == PAUSE);
  assign tick      = tick_q;
  assign err       = err_q;
  assign done      = done_q;

  // a config transfer on the same edge swallows start
  assign cfg_acc  = cfg_valid & cfg_ready;
  assign start_go = ~stop & ~cfg_acc & start & (limit_q != '0);

  cnt8_core u_core (
    .clk             (clk),
    .rst             (rst),
    .clr_i           (core_clr),
    .en_i            (core_en),
    .hold_at_limit_i (~periodic_q),
    .limit_i         (limit_q),
    .value_o         (count),
    .at_limit_o      (at_limit)
  );

  // next state, config capture and core control by edge priority
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    err_d      = 1'b0;
    done_d     = done_q;
    core_clr   = 1'b0;
    core_en    = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      core_clr = 1'b1;
    end else if (cfg_acc) begin
      limit_d    = cfg_limit;
      periodic_d = cfg_periodic;
    end else if (start) begin
      if (start_go) begin
        state_d  = RUN;
        done_d   = 1'b0;
        core_clr = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (ss) begin
            core_en = 1'b1;
            if (at_limit) begin
              tick_d = 1'b1;
              if (!periodic_q) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
        end
        IDLE: ;
        DONE: ;
      endcase
    end
  end

  // controller registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      limit_q    <= DEFAULT_LIMIT;
      periodic_q <= DEFAULT_PERIODIC;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

`ifdef CNT8_TICK_COUNT_EN
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  assign tick_cnt = tick_cnt_q;

  // saturating tick tally, restarted by stop or accepted start
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (stop || start_go) begin
      tick_cnt_d = '0;
    end else if (tick_d && (tick_cnt_q != CNT_MAX)) begin
      tick_cnt_d = tick_cnt_q + 8'd1;
    end
  end

  // tick tally register
  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end
`else
  assign tick_cnt = '0;
`endif

endmodule

// File: tb/tb_cnt8_seq_ctrl.sv
// Directed bench for cnt8_seq_ctrl with an expectation queue.
// Build with CNT8_TICK_COUNT_EN to expect a live tick_cnt.
module tb_cnt8_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_limit;
  logic       cfg_periodic;
  logic       start;
  logic       stop;
  logic       pause;
  logic       ss;
  logic [7:0] count;
  logic       tick;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] tick_cnt;

`ifdef CNT8_TICK_COUNT_EN
  localparam logic [7:0] TC_SAT = 8'hFF;
`else
  localparam logic [7:0] TC_SAT = 8'h00;
`endif

  cnt8_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_limit    (cfg_limit),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .ss           (ss),
    .count        (count),
    .tick         (tick),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .tick_cnt     (tick_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic       t;
    logic       b;
    logic       d;
    logic       e;
    logic       r;
    logic       tce;
    logic [7:0] tc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cyc(
    input string      tag,
    input logic [7:0] c,
    input logic       t,
    input logic       b,
    input logic       d,
    input logic       e,
    input logic       r,
    input logic       tce = 1'b0,
    input logic [7:0] tc  = 8'h00
  );
    exp_t x;
    x.tag = tag; x.cnt = c; x.t = t; x.b = b;
    x.d = d; x.e = e; x.r = r; x.tce = tce; x.tc = tc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    n_cmp++;
    assert ({count, tick, busy, done, err, cfg_ready}
            === {x.cnt, x.t, x.b, x.d, x.e, x.r})
    else begin
      n_bad++;
      $error("FAIL %s: observed cnt=%0d tick=%b busy=%b done=%b err=%b rdy=%b expected cnt=%0d tick=%b busy=%b done=%b err=%b rdy=%b",
             x.tag, count, tick, busy, done, err, cfg_ready,
             x.cnt, x.t, x.b, x.d, x.e, x.r);
    end
    if (x.tce) begin
      n_cmp++;
      assert (tick_cnt === x.tc)
      else begin
        n_bad++;
        $error("FAIL %s_tc: observed tick_cnt=%0d expected %0d",
               x.tag, tick_cnt, x.tc);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_limit = 8'h00;
    cfg_periodic = 1'b0; start = 1'b0; stop = 1'b0;
    pause = 1'b0; ss = 1'b0;

    cyc("rst0", 8'd0, 0, 0, 0, 0, 1, 1, 8'd0);
    cyc("rst1", 8'd0, 0, 0, 0, 0, 1, 1, 8'd0);
    rst = 1'b0;

    // default limit 255, one-shot
    start = 1'b1;
    cyc("ro_start", 8'd0, 0, 1, 0, 0, 0);
    start = 1'b0; ss = 1'b1;
    for (int i = 1; i <= 255; i++)
      cyc("ro_cnt", 8'(i), 0, 1, 0, 0, 0);
    cyc("ro_tick", 8'd255, 1, 0, 1, 0, 1);
    cyc("ro_hold", 8'd255, 0, 0, 1, 0, 1);
    ss = 1'b0;

    // periodic limit 3, cfg held during RUN
    cfg_valid = 1'b1; cfg_limit = 8'd3; cfg_periodic = 1'b1;
    cyc("p_cfg", 8'd255, 0, 0, 1, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    cyc("p_start", 8'd0, 0, 1, 0, 0, 0);
    start = 1'b0; ss = 1'b1;
    cfg_valid = 1'b1; cfg_limit = 8'd7; cfg_periodic = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 13) cfg_valid = 1'b0;
      cyc("p_run", 8'(k % 4), (k % 4 == 0), 1, 0, 0, 0);
    end
    stop = 1'b1;
    cyc("p_stop", 8'd0, 0, 0, 0, 0, 1);
    stop = 1'b0; ss = 1'b0;

    // one-shot limit 5 with ss gating
    cfg_valid = 1'b1; cfg_limit = 8'd5; cfg_periodic = 1'b0;
    cyc("o_cfg", 8'd0, 0, 0, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    cyc("o_start", 8'd0, 0, 1, 0, 0, 0);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ss = (i % 2 == 0);
      cyc("o_gate", 8'((i / 2 + 1 > 5) ? 5 : i / 2 + 1),
          (i == 10), (i < 10), (i >= 10), 0, (i >= 10));
    end
    ss = 1'b1;
    cyc("o_hold", 8'd5, 0, 0, 1, 0, 1);
    cfg_valid = 1'b1; cfg_limit = 8'd10; cfg_periodic = 1'b1;
    start = 1'b1;
    cyc("o_cfg_start", 8'd5, 0, 0, 1, 0, 1);
    cfg_valid = 1'b0; start = 1'b0;

    // pause and stop, limit 10 periodic
    start = 1'b1;
    cyc("ps_start", 8'd0, 0, 1, 0, 0, 0);
    start = 1'b0; ss = 1'b1;
    for (int i = 1; i <= 4; i++)
      cyc("ps_cnt", 8'(i), 0, 1, 0, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("ps_hold", 8'd4, 0, 1, 0, 0, 0);
    pause = 1'b0;
    cyc("ps_resume", 8'd4, 0, 1, 0, 0, 0);
    for (int i = 5; i <= 7; i++)
      cyc("ps_run", 8'(i), 0, 1, 0, 0, 0);
    stop = 1'b1;
    cyc("ps_stop", 8'd0, 0, 0, 0, 0, 1);
    stop = 1'b0; ss = 1'b0;

    // limit 0 rejects start
    cfg_valid = 1'b1; cfg_limit = 8'd0; cfg_periodic = 1'b1;
    cyc("b_cfg0", 8'd0, 0, 0, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    cyc("b_err", 8'd0, 0, 0, 0, 1, 1);
    start = 1'b0;
    cyc("b_err_clr", 8'd0, 0, 0, 0, 0, 1);

    // start with stop, then reset mid-RUN
    cfg_valid = 1'b1; cfg_limit = 8'd12;
    cyc("b_cfg12", 8'd0, 0, 0, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    cyc("b_start", 8'd0, 0, 1, 0, 0, 0);
    stop = 1'b1;
    cyc("b_start_stop", 8'd0, 0, 0, 0, 0, 1);
    stop = 1'b0;
    cyc("b_restart", 8'd0, 0, 1, 0, 0, 0);
    start = 1'b0; ss = 1'b1;
    for (int i = 1; i <= 9; i++)
      cyc("b_cnt", 8'(i), 0, 1, 0, 0, 0);
    rst = 1'b1;
    cyc("b_rst", 8'd0, 0, 0, 0, 0, 1, 1, 8'd0);
    rst = 1'b0; start = 1'b1;
    cyc("b_rst_start", 8'd0, 0, 1, 0, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 13; i++)
      cyc("b_deflim", 8'(i), 0, 1, 0, 0, 0);
    stop = 1'b1;
    cyc("b_stop", 8'd0, 0, 0, 0, 0, 1);
    stop = 1'b0; ss = 1'b0;

    // tick tally over 300 ticks
    cfg_valid = 1'b1; cfg_limit = 8'd1; cfg_periodic = 1'b1;
    cyc("t_cfg", 8'd0, 0, 0, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    cyc("t_start", 8'd0, 0, 1, 0, 0, 0, 1, 8'd0);
    start = 1'b0; ss = 1'b1;
    repeat (599) @(posedge clk);
    #1;
    cyc("t_sat", 8'd0, 1, 1, 0, 0, 0, 1, TC_SAT);
    stop = 1'b1;
    cyc("t_stop", 8'd0, 0, 0, 0, 0, 1, 1, 8'd0);
    stop = 1'b0; ss = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
